// File: rtl/bnn_pkg.sv
// Shared types and constants for the binarized-neuron accumulate sequencer.
package bnn_pkg;

    localparam int BNN_ACC_W = 12;
    localparam int BNN_LEN_W = 8;

    localparam logic [1:0] BNN_ST_IDLE = 2'd0;
    localparam logic [1:0] BNN_ST_ACC  = 2'd1;
    localparam logic [1:0] BNN_ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = BNN_ST_IDLE,
        ST_ACC  = BNN_ST_ACC,
        ST_DONE = BNN_ST_DONE
    } bnn_state_e;

    // xnor-popcount: a matching (x, w) pair adds one, a mismatch subtracts one
    localparam logic BNN_OP_ADD1 = 1'b0;
    localparam logic BNN_OP_SUB1 = 1'b1;

endpackage

// File: rtl/bnn_acc_step.sv
// Combinational +/-1 step on the signed accumulator with overflow detection.
// Optional macro BNN_ACC_SAT_EN: clamp at the signed limits instead of wrapping.
module bnn_acc_step
    import bnn_pkg::*;
#(
    parameter int ACC_W = BNN_ACC_W
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic             op_i,
    output logic [ACC_W-1:0] next_acc_o,
    output logic             ovf_o
);

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] ACC_ONE = {{(ACC_W-1){1'b0}}, 1'b1};

    logic [ACC_W-1:0] raw;

    always_comb begin
        raw   = acc_i;
        ovf_o = 1'b0;
        if (op_i == BNN_OP_ADD1) begin
            raw   = acc_i + ACC_ONE;
            ovf_o = (acc_i == ACC_MAX);
        end else begin
            raw   = acc_i - ACC_ONE;
            ovf_o = (acc_i == ACC_MIN);
        end
`ifdef BNN_ACC_SAT_EN
        // an overflowing step only happens from the limit itself, so holding acc clamps it
        next_acc_o = ovf_o ? acc_i : raw;
`else
        next_acc_o = raw;
`endif
    end

endmodule

// File: rtl/bnn_neuron_seq.sv
// Sequencer for one binarized-neuron evaluation: bias load, len +/-1 steps, result handshake.
// Optional macro BNN_ACC_SAT_EN selects saturating accumulation inside bnn_acc_step.
module bnn_neuron_seq
    import bnn_pkg::*;
#(
    parameter int ACC_W = BNN_ACC_W,
    parameter int LEN_W = BNN_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [ACC_W-1:0] bias_i,
    input  logic             clr_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             in_x_i,
    input  logic             in_w_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [ACC_W-1:0] acc_out_o,
    output logic             act_out_o,
    output logic             ovf_o,
    output logic             busy_o,
    output logic [1:0]       dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // ready/valid driven here come straight from the state register.

    localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    bnn_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] step_acc;
    logic             step_ovf;

    bnn_acc_step #(.ACC_W(ACC_W)) u_step (
        .acc_i      (acc_q),
        .op_i       (in_x_i ^ in_w_i),
        .next_acc_o (step_acc),
        .ovf_o      (step_ovf)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clr_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        acc_d   = bias_i;
                        cnt_d   = len_i;
                        ovf_d   = 1'b0;
                        state_d = (len_i != '0) ? ST_ACC : ST_DONE;
                    end
                end
                ST_ACC: begin
                    if (in_valid_i) begin
                        acc_d = step_acc;
                        ovf_d = ovf_q | step_ovf;
                        cnt_d = cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready_o  = (state_q == ST_ACC);
    assign out_valid_o = (state_q == ST_DONE);
    assign busy_o      = (state_q != ST_IDLE);
    assign acc_out_o   = acc_q;
    assign act_out_o   = ~acc_q[ACC_W-1];
    assign ovf_o       = ovf_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bnn_neuron_seq.sv
// Self-checking bench for bnn_neuron_seq: integer reference model feeding an expected-result queue.
module tb_bnn_neuron_seq;

    localparam int ACC_W = 12;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_i = 1'b0;
    logic [LEN_W-1:0] len_i = '0;
    logic [ACC_W-1:0] bias_i = '0;
    logic             clr_i = 1'b0;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    logic             in_x_i = 1'b0;
    logic             in_w_i = 1'b0;
    logic             out_valid_o;
    logic             out_ready_i = 1'b1;
    logic [ACC_W-1:0] acc_out_o;
    logic             act_out_o;
    logic             ovf_o;
    logic             busy_o;
    logic [1:0]       dbg_state_o;

    int checks = 0;
    int errors = 0;

    logic [ACC_W+1:0] exp_q[$];
    bit               px[0:255];
    bit               pw[0:255];

    bnn_neuron_seq #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .len_i       (len_i),
        .bias_i      (bias_i),
        .clr_i       (clr_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_x_i      (in_x_i),
        .in_w_i      (in_w_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .acc_out_o   (acc_out_o),
        .act_out_o   (act_out_o),
        .ovf_o       (ovf_o),
        .busy_o      (busy_o),
        .dbg_state_o (dbg_state_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: signed integer sum of +1 per matching pair, -1 per mismatch
    function automatic logic [ACC_W+1:0] model(input logic [ACC_W-1:0] b, input int n);
        int               acc;
        bit               ov;
        logic [ACC_W-1:0] a12;
        acc = $signed(b);
        ov  = 1'b0;
        for (int i = 0; i < n; i++) begin
            acc = (px[i] == pw[i]) ? acc + 1 : acc - 1;
            if (acc > 2047) begin
                ov = 1'b1;
`ifdef BNN_ACC_SAT_EN
                acc = 2047;
`else
                acc = acc - 4096;
`endif
            end else if (acc < -2048) begin
                ov = 1'b1;
`ifdef BNN_ACC_SAT_EN
                acc = -2048;
`else
                acc = acc + 4096;
`endif
            end
        end
        a12 = acc[ACC_W-1:0];
        return {ov, (acc >= 0), a12};
    endfunction

    // monitor: pop on every result transfer, and require stable outputs while backpressured
    logic             hold_v = 1'b0;
    logic [ACC_W+1:0] hold_val = '0;
    logic [ACC_W+1:0] exp_v;

    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) chk("hold_stable", {out_valid_o, ovf_o, act_out_o, acc_out_o}, {1'b1, hold_val});
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    exp_v = exp_q.pop_front();
                    chk("acc_out", acc_out_o, exp_v[ACC_W-1:0]);
                    chk("act_out", act_out_o, exp_v[ACC_W]);
                    chk("ovf", ovf_o, exp_v[ACC_W+1]);
                end
            end
            hold_v   = out_valid_o && !out_ready_i;
            hold_val = {ovf_o, act_out_o, acc_out_o};
        end
    end

    // driver tasks: all inputs change 1 time unit after the rising edge
    task automatic fill(input int mode, input int n);
        for (int i = 0; i < n; i++) begin
            px[i] = 1'($urandom_range(0, 1));
            case (mode)
                1:       pw[i] = px[i];
                2:       pw[i] = ~px[i];
                default: pw[i] = 1'($urandom_range(0, 1));
            endcase
        end
    endtask

    task automatic do_start(input logic [ACC_W-1:0] b, input int n);
        int k;
        for (k = 0; k < 100 && busy_o; k++) begin
            @(posedge clk); #1;
        end
        if (k == 100) chk("start_wait_timeout", 32'd1, 32'd0);
        start_i = 1'b1;
        bias_i  = b;
        len_i   = LEN_W'(n);
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("busy_after_start", busy_o, 1'b1);
    endtask

    // stall: 0 none, 1 random bubbles, 2 one bubble between pairs
    task automatic drive_pairs(input int n, input int stall, input bit last);
        for (int i = 0; i < n; i++) begin
            if (stall == 2 && i > 0) begin
                in_valid_i = 1'b0;
                @(posedge clk); #1;
            end
            while (stall == 1 && $urandom_range(0, 2) == 0) begin
                in_valid_i = 1'b0;
                @(posedge clk); #1;
            end
            chk("in_ready_in_acc", in_ready_o, 1'b1);
            chk("no_early_valid", out_valid_o, 1'b0);
            in_valid_i = 1'b1;
            in_x_i     = px[i];
            in_w_i     = pw[i];
            @(posedge clk); #1;
        end
        in_valid_i = 1'b0;
        if (last) chk("out_valid_after_last", out_valid_o, 1'b1);
    endtask

    task automatic wait_done(input bit rand_rdy);
        int k;
        for (k = 0; k < 200; k++) begin
            out_ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (out_valid_o && out_ready_i) break;
            @(posedge clk); #1;
        end
        if (k == 200) chk("done_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        out_ready_i = 1'b1;
    endtask

    task automatic run_eval(input logic [ACC_W-1:0] b, input int n, input int stall, input bit rand_rdy);
        exp_q.push_back(model(b, n));
        do_start(b, n);
        if (n == 0) chk("len0_no_in_ready", in_ready_o, 1'b0);
        drive_pairs(n, stall, 1'b1);
        wait_done(rand_rdy);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready_o, 1'b0);
        chk({tag, "_out_valid"}, out_valid_o, 1'b0);
        chk({tag, "_acc_out"}, acc_out_o, '0);
        chk({tag, "_act_out"}, act_out_o, 1'b1);
        chk({tag, "_ovf"}, ovf_o, 1'b0);
        chk({tag, "_busy"}, busy_o, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // x=1010, w=1010: all match
        px[0] = 1; px[1] = 0; px[2] = 1; px[3] = 0;
        pw[0] = 1; pw[1] = 0; pw[2] = 1; pw[3] = 0;
        run_eval(12'd0, 4, 0, 1'b0);

        fill(2, 8);
        run_eval(12'd3, 8, 0, 1'b0);
        fill(1, 1);
        run_eval(12'hFFF, 1, 0, 1'b0);

        run_eval(12'hFFE, 0, 0, 1'b0);

        fill(0, 3);
        run_eval(12'd7, 3, 2, 1'b0);

        // backpressure with an ignored start pulse while the result is held
        fill(0, 5);
        exp_q.push_back(model(12'd20, 5));
        out_ready_i = 1'b0;
        do_start(12'd20, 5);
        drive_pairs(5, 0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            start_i = (i == 2);
            bias_i  = 12'd100;
            len_i   = 8'd3;
            @(posedge clk); #1;
            chk("bp_out_valid", out_valid_o, 1'b1);
        end
        start_i = 1'b0;
        wait_done(1'b0);
        chk("bp_start_dropped", busy_o, 1'b0);

        fill(1, 16);
        run_eval(12'd2040, 16, 0, 1'b0);
        fill(2, 10);
        run_eval(12'h803, 10, 1, 1'b0);

        // clr after 3 of 10 pairs
        fill(0, 10);
        do_start(12'd5, 10);
        drive_pairs(3, 0, 1'b0);
        clr_i = 1'b1;
        @(posedge clk); #1;
        clr_i = 1'b0;
        chk("clr_in_ready", in_ready_o, 1'b0);
        chk("clr_busy", busy_o, 1'b0);
        chk("clr_out_valid", out_valid_o, 1'b0);
        clr_i   = 1'b1;
        start_i = 1'b1;
        @(posedge clk); #1;
        clr_i   = 1'b0;
        start_i = 1'b0;
        chk("clr_beats_start", busy_o, 1'b0);
        fill(0, 6);
        run_eval(12'hFF0, 6, 0, 1'b0);

        // asynchronous reset mid-accumulation
        fill(0, 10);
        do_start(12'd9, 10);
        drive_pairs(2, 0, 1'b0);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int r = 0; r < 25; r++) begin
            logic [ACC_W-1:0] b;
            int               n;
            n = $urandom_range(0, 24);
            case ($urandom_range(0, 3))
                0:       b = 12'd2047 - 12'($urandom_range(0, 10));
                1:       b = 12'h800 + 12'($urandom_range(0, 10));
                default: b = 12'($urandom_range(0, 4095));
            endcase
            fill($urandom_range(0, 2), n);
            run_eval(b, n, $urandom_range(0, 2), 1'b1);
        end

        repeat (3) @(posedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
